// File: rtl/fastram_bus_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fastram_bus_frontend
// Purpose  : 68000-side front end for the SDRAM fast-RAM controller.
//            Synchronises the CPU strobes, decodes the fast-RAM window and
//            passes a qualified cycle to the controller. It turns the
//            controller's VALID into DTACK, the read-latch strobe and the
//            data-buffer controls, and raises BERR when an access stalls.
// Ports    : CLK, RST (sync, active low)
//            CPU_AS/UDS/LDS/RW/A  - raw 68000 bus (strobes asynchronous)
//            SD_READY, SD_VALID   - controller status (VALID active low)
//            SD_AS/UDS/LDS/RW/A   - qualified cycle towards the controller
//            DTACK, BERR          - CPU handshake, active low
//            DLATCH               - one-cycle read-data capture strobe
//            BUF_OE, BUF_DIR      - data buffer enable (low) / direction
// Revision : 1.0 - initial release
// ============================================================================
module fastram_bus_frontend #(
    parameter logic [2:0]  WIN_MATCH = 3'b001,
    parameter logic [2:0]  WIN_MASK  = 3'b111,
    parameter logic [11:0] TIMEOUT   = 12'd2047
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_AS,
    input  logic        CPU_UDS,
    input  logic        CPU_LDS,
    input  logic        CPU_RW,
    input  logic [23:1] CPU_A,
    input  logic        SD_READY,
    input  logic        SD_VALID,
    output logic        SD_AS,
    output logic        SD_UDS,
    output logic        SD_LDS,
    output logic        SD_RW,
    output logic [23:1] SD_A,
    output logic        DTACK,
    output logic        BERR,
    output logic        DLATCH,
    output logic        BUF_OE,
    output logic        BUF_DIR
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INITWAIT = 3'd1,
        ST_IGNORE   = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_LATCH    = 3'd4,
        ST_ACK      = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    state_t      r_state_q, w_state_d;
    // Two-stage synchronisers, bit order {AS, UDS, LDS, RW}
    logic [3:0]  r_meta_q, w_meta_d;
    logic [3:0]  r_sync_q, w_sync_d;
    logic [11:0] r_cnt_q, w_cnt_d;
    logic        r_sd_as_q, w_sd_as_d;
    logic        r_sd_uds_q, w_sd_uds_d;
    logic        r_sd_lds_q, w_sd_lds_d;
    logic        r_sd_rw_q, w_sd_rw_d;
    logic [23:1] r_sd_a_q, w_sd_a_d;
    logic        r_dtack_q, w_dtack_d;
    logic        r_berr_q, w_berr_d;
    logic        r_dlatch_q, w_dlatch_d;
    logic        r_buf_oe_q, w_buf_oe_d;
    logic        r_buf_dir_q, w_buf_dir_d;

    logic        w_as_s, w_uds_s, w_lds_s, w_rw_s;
    logic        w_hit;
    logic        w_start;
    logic        w_release;

    assign w_as_s  = r_sync_q[3];
    assign w_uds_s = r_sync_q[2];
    assign w_lds_s = r_sync_q[1];
    assign w_rw_s  = r_sync_q[0];

    // Address is decoded unsynchronised: the 68k holds A stable before AS
    // has propagated through the synchronisers.
    assign w_hit = ((CPU_A[23:21] & WIN_MASK) == (WIN_MATCH & WIN_MASK));

    always_comb begin
        w_meta_d    = {CPU_AS, CPU_UDS, CPU_LDS, CPU_RW};
        w_sync_d    = r_meta_q;
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_sd_as_d   = r_sd_as_q;
        w_sd_uds_d  = r_sd_uds_q;
        w_sd_lds_d  = r_sd_lds_q;
        w_sd_rw_d   = r_sd_rw_q;
        w_sd_a_d    = r_sd_a_q;
        w_dtack_d   = r_dtack_q;
        w_berr_d    = r_berr_q;
        w_dlatch_d  = 1'b0;
        w_buf_oe_d  = r_buf_oe_q;
        w_buf_dir_d = r_buf_dir_q;
        w_start     = 1'b0;
        w_release   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (!w_as_s) begin
                    if (!w_hit)
                        w_state_d = ST_IGNORE;
                    else if (SD_READY)
                        w_state_d = ST_INITWAIT;
                    else
                        w_start = 1'b1;
                end
            end
            ST_INITWAIT: begin
                if (w_as_s)
                    w_state_d = ST_IDLE;
                else if (!SD_READY)
                    w_start = 1'b1;
            end
            ST_IGNORE: begin
                if (w_as_s)
                    w_state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                w_sd_uds_d = w_uds_s;
                w_sd_lds_d = w_lds_s;
                w_buf_oe_d = 1'b0;
                w_cnt_d    = (r_cnt_q == TIMEOUT) ? r_cnt_q : r_cnt_q + 12'd1;
                // Abort beats VALID, VALID beats timeout
                if (w_as_s) begin
                    w_release = 1'b1;
                    w_state_d = ST_IDLE;
                end else if (!SD_VALID) begin
                    if (r_sd_rw_q) begin
                        w_dlatch_d = 1'b1;
                        w_state_d  = ST_LATCH;
                    end else begin
                        w_dtack_d = 1'b0;
                        w_state_d = ST_ACK;
                    end
                end else if (r_cnt_q == TIMEOUT) begin
                    w_berr_d  = 1'b0;
                    w_state_d = ST_ERR;
                end
            end
            ST_LATCH: begin
                // Read data was captured last cycle; acknowledge now
                w_dtack_d = 1'b0;
                w_state_d = ST_ACK;
            end
            ST_ACK, ST_ERR: begin
                if (w_as_s) begin
                    w_release = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_d   = ST_ACCESS;
            w_sd_as_d   = 1'b0;
            w_sd_rw_d   = w_rw_s;
            w_sd_a_d    = CPU_A;
            w_buf_dir_d = w_rw_s;
            w_cnt_d     = 12'd0;
        end

        // RW, A and DIR stay latched so the buffer direction never flips
        // while the CPU is still driving or sampling the bus.
        if (w_release) begin
            w_sd_as_d  = 1'b1;
            w_sd_uds_d = 1'b1;
            w_sd_lds_d = 1'b1;
            w_dtack_d  = 1'b1;
            w_berr_d   = 1'b1;
            w_buf_oe_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_meta_q    <= 4'hF;
            r_sync_q    <= 4'hF;
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= 12'd0;
            r_sd_as_q   <= 1'b1;
            r_sd_uds_q  <= 1'b1;
            r_sd_lds_q  <= 1'b1;
            r_sd_rw_q   <= 1'b1;
            r_sd_a_q    <= '0;
            r_dtack_q   <= 1'b1;
            r_berr_q    <= 1'b1;
            r_dlatch_q  <= 1'b0;
            r_buf_oe_q  <= 1'b1;
            r_buf_dir_q <= 1'b0;
        end else begin
            r_meta_q    <= w_meta_d;
            r_sync_q    <= w_sync_d;
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_sd_as_q   <= w_sd_as_d;
            r_sd_uds_q  <= w_sd_uds_d;
            r_sd_lds_q  <= w_sd_lds_d;
            r_sd_rw_q   <= w_sd_rw_d;
            r_sd_a_q    <= w_sd_a_d;
            r_dtack_q   <= w_dtack_d;
            r_berr_q    <= w_berr_d;
            r_dlatch_q  <= w_dlatch_d;
            r_buf_oe_q  <= w_buf_oe_d;
            r_buf_dir_q <= w_buf_dir_d;
        end
    end

    assign SD_AS   = r_sd_as_q;
    assign SD_UDS  = r_sd_uds_q;
    assign SD_LDS  = r_sd_lds_q;
    assign SD_RW   = r_sd_rw_q;
    assign SD_A    = r_sd_a_q;
    assign DTACK   = r_dtack_q;
    assign BERR    = r_berr_q;
    assign DLATCH  = r_dlatch_q;
    assign BUF_OE  = r_buf_oe_q;
    assign BUF_DIR = r_buf_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_fastram_bus_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fastram_bus_frontend
// Purpose  : Self-checking bench for fastram_bus_frontend. A table of bus
//            cycles (hit/miss, read/write, byte lanes) is replayed in a loop;
//            init-wait, timeout, abort and reset corner cases are driven as
//            hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fastram_bus_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_as, cpu_uds, cpu_lds, cpu_rw;
    logic [23:1] cpu_a;
    logic        sd_ready, sd_valid;
    logic        sd_as, sd_uds, sd_lds, sd_rw;
    logic [23:1] sd_a;
    logic        dtack, berr, dlatch, buf_oe, buf_dir;

    always #5 clk = ~clk;

    fastram_bus_frontend dut (
        .CLK      (clk),
        .RST      (rst_n),
        .CPU_AS   (cpu_as),
        .CPU_UDS  (cpu_uds),
        .CPU_LDS  (cpu_lds),
        .CPU_RW   (cpu_rw),
        .CPU_A    (cpu_a),
        .SD_READY (sd_ready),
        .SD_VALID (sd_valid),
        .SD_AS    (sd_as),
        .SD_UDS   (sd_uds),
        .SD_LDS   (sd_lds),
        .SD_RW    (sd_rw),
        .SD_A     (sd_a),
        .DTACK    (dtack),
        .BERR     (berr),
        .DLATCH   (dlatch),
        .BUF_OE   (buf_oe),
        .BUF_DIR  (buf_dir)
    );

    typedef struct {
        logic [23:0] addr;   // byte address
        logic        rw;
        logic        uds;
        logic        lds;
        logic        hit;    // hand-decoded A[23:21] == 3'b001
        int          dly;    // cycles in ACCESS before VALID (>= 1)
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dl_pulses = 0;

    always @(negedge clk) if (dlatch === 1'b1) dl_pulses <= dl_pulses + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cpu_as   = 1'b1;
        cpu_uds  = 1'b1;
        cpu_lds  = 1'b1;
        cpu_rw   = 1'b1;
        sd_valid = 1'b1;
    endtask

    task automatic cpu_start(input logic [23:0] addr, input logic rw, input logic uds, input logic lds);
        cpu_a   = addr[23:1];
        cpu_rw  = rw;
        cpu_uds = uds;
        cpu_lds = lds;
        cpu_as  = 1'b0;
    endtask

    task automatic cpu_release();
        cpu_as  = 1'b1;
        cpu_uds = 1'b1;
        cpu_lds = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".sd_as"},   {31'd0, sd_as},   32'd1);
        check({tag, ".sd_uds"},  {31'd0, sd_uds},  32'd1);
        check({tag, ".sd_lds"},  {31'd0, sd_lds},  32'd1);
        check({tag, ".sd_rw"},   {31'd0, sd_rw},   32'd1);
        check({tag, ".sd_a"},    {9'd0, sd_a},     32'd0);
        check({tag, ".dtack"},   {31'd0, dtack},   32'd1);
        check({tag, ".berr"},    {31'd0, berr},    32'd1);
        check({tag, ".dlatch"},  {31'd0, dlatch},  32'd0);
        check({tag, ".buf_oe"},  {31'd0, buf_oe},  32'd1);
        check({tag, ".buf_dir"}, {31'd0, buf_dir}, 32'd0);
    endtask

    task automatic check_released(input string tag);
        check({tag, ".sd_as"},  {31'd0, sd_as},  32'd1);
        check({tag, ".sd_uds"}, {31'd0, sd_uds}, 32'd1);
        check({tag, ".sd_lds"}, {31'd0, sd_lds}, 32'd1);
        check({tag, ".dtack"},  {31'd0, dtack},  32'd1);
        check({tag, ".berr"},   {31'd0, berr},   32'd1);
        check({tag, ".buf_oe"}, {31'd0, buf_oe}, 32'd1);
        check({tag, ".dlatch"}, {31'd0, dlatch}, 32'd0);
    endtask

    // From the first ACCESS cycle: VALID low -> DLATCH, then DTACK, then release.
    task automatic finish_read(input string tag);
        sd_valid = 1'b0;
        tick();
        check({tag, ".dlatch"}, {31'd0, dlatch}, 32'd1);
        check({tag, ".dtack_early"}, {31'd0, dtack}, 32'd1);
        sd_valid = 1'b1;
        tick();
        check({tag, ".dtack"}, {31'd0, dtack}, 32'd0);
        cpu_release();
        ticks(3);
        check_released({tag, ".rel"});
    endtask

    task automatic run_access(input vec_t v, input int idx);
        string tag;
        int    dl0;
        tag = $sformatf("vec%0d", idx);
        dl0 = dl_pulses;
        cpu_start(v.addr, v.rw, v.uds, v.lds);
        ticks(2);
        check({tag, ".sd_as_pre"}, {31'd0, sd_as}, 32'd1);
        tick();
        if (v.hit) begin
            check({tag, ".sd_as_fall"}, {31'd0, sd_as}, 32'd0);
            check({tag, ".sd_a"}, {9'd0, sd_a}, {9'd0, v.addr[23:1]});
            check({tag, ".sd_rw"}, {31'd0, sd_rw}, {31'd0, v.rw});
            check({tag, ".buf_dir"}, {31'd0, buf_dir}, {31'd0, v.rw});
            tick();
            check({tag, ".sd_uds"}, {31'd0, sd_uds}, {31'd0, v.uds});
            check({tag, ".sd_lds"}, {31'd0, sd_lds}, {31'd0, v.lds});
            check({tag, ".buf_oe"}, {31'd0, buf_oe}, 32'd0);
            ticks(v.dly - 1);
            check({tag, ".dtack_wait"}, {31'd0, dtack}, 32'd1);
            sd_valid = 1'b0;
            tick();
            if (v.rw) begin
                check({tag, ".dlatch_hi"}, {31'd0, dlatch}, 32'd1);
                check({tag, ".dtack_n"}, {31'd0, dtack}, 32'd1);
                sd_valid = 1'b1;
                tick();
                check({tag, ".dlatch_lo"}, {31'd0, dlatch}, 32'd0);
                check({tag, ".dtack_n1"}, {31'd0, dtack}, 32'd0);
            end else begin
                check({tag, ".dtack_n"}, {31'd0, dtack}, 32'd0);
                check({tag, ".dlatch_w"}, {31'd0, dlatch}, 32'd0);
                sd_valid = 1'b1;
                tick();
                check({tag, ".dtack_hold"}, {31'd0, dtack}, 32'd0);
            end
            check({tag, ".buf_dir_ack"}, {31'd0, buf_dir}, {31'd0, v.rw});
            cpu_release();
            ticks(2);
            check({tag, ".dtack_rel_pre"}, {31'd0, dtack}, 32'd0);
            tick();
            check_released({tag, ".rel"});
        end else begin
            ticks(4);
            check({tag, ".miss_sd_as"}, {31'd0, sd_as}, 32'd1);
            check({tag, ".miss_dtack"}, {31'd0, dtack}, 32'd1);
            check({tag, ".miss_berr"}, {31'd0, berr}, 32'd1);
            check({tag, ".miss_buf_oe"}, {31'd0, buf_oe}, 32'd1);
            cpu_release();
            ticks(3);
            check_released({tag, ".rel"});
        end
        tick();
        check({tag, ".dlatch_pulses"}, dl_pulses - dl0, v.rw && v.hit ? 32'd1 : 32'd0);
    endtask

    initial begin
        int  bad_flag;

        vecs[0] = '{addr: 24'h200000, rw: 1'b1, uds: 1'b0, lds: 1'b0, hit: 1'b1, dly: 6};
        vecs[1] = '{addr: 24'h3FFFFE, rw: 1'b0, uds: 1'b0, lds: 1'b1, hit: 1'b1, dly: 3};
        vecs[2] = '{addr: 24'h100000, rw: 1'b1, uds: 1'b0, lds: 1'b0, hit: 1'b0, dly: 1};
        vecs[3] = '{addr: 24'h2ABCDE, rw: 1'b1, uds: 1'b1, lds: 1'b0, hit: 1'b1, dly: 1};
        vecs[4] = '{addr: 24'hE00000, rw: 1'b0, uds: 1'b0, lds: 1'b0, hit: 1'b0, dly: 1};
        vecs[5] = '{addr: 24'h200002, rw: 1'b0, uds: 1'b0, lds: 1'b0, hit: 1'b1, dly: 2};
        vecs[6] = '{addr: 24'h400000, rw: 1'b1, uds: 1'b0, lds: 1'b0, hit: 1'b0, dly: 1};

        rst_n    = 1'b0;
        sd_ready = 1'b0;
        cpu_a    = '0;
        bus_idle();
        ticks(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        ticks(2);

        for (int i = 0; i < 7; i++) run_access(vecs[i], i);

        // Controller still initialising: park in INITWAIT, no BERR
        sd_ready = 1'b1;
        cpu_start(24'h200000, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check("initwait.sd_as", {31'd0, sd_as}, 32'd1);
        bad_flag = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (berr !== 1'b1 || sd_as !== 1'b1 || dtack !== 1'b1) bad_flag = 1;
        end
        check("initwait.quiet", bad_flag, 32'd0);
        sd_ready = 1'b0;
        tick();
        check("initwait.sd_as_fall", {31'd0, sd_as}, 32'd0);
        finish_read("initwait");

        // VALID never comes: BERR exactly when the counter hits 2047
        cpu_start(24'h200000, 1'b1, 1'b0, 1'b0);
        ticks(3);
        check("timeout.sd_as", {31'd0, sd_as}, 32'd0);
        bad_flag = 0;
        for (int i = 0; i < 2047; i++) begin
            tick();
            if (berr !== 1'b1 || dtack !== 1'b1) bad_flag = 1;
        end
        check("timeout.early", bad_flag, 32'd0);
        tick();
        check("timeout.berr", {31'd0, berr}, 32'd0);
        check("timeout.dtack", {31'd0, dtack}, 32'd1);
        cpu_release();
        ticks(2);
        check("timeout.berr_hold", {31'd0, berr}, 32'd0);
        tick();
        check_released("timeout.rel");

        // VALID on the same cycle the counter reaches TIMEOUT: VALID wins
        cpu_start(24'h200000, 1'b1, 1'b0, 1'b0);
        ticks(3);
        ticks(2047);
        check("tie.berr_pre", {31'd0, berr}, 32'd1);
        finish_read("tie");
        check("tie.berr_after", {31'd0, berr}, 32'd1);

        // Abort before VALID
        cpu_start(24'h200000, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cpu_release();
        ticks(2);
        check("abort.sd_as_hold", {31'd0, sd_as}, 32'd0);
        tick();
        check_released("abort.rel");

        // Abort landing on the same cycle as VALID: no DTACK, no DLATCH
        cpu_start(24'h200000, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cpu_release();
        ticks(2);
        sd_valid = 1'b0;
        tick();
        check_released("abort_valid.rel");
        sd_valid = 1'b1;
        tick();
        check("abort_valid.dtack", {31'd0, dtack}, 32'd1);
        check("abort_valid.dlatch", {31'd0, dlatch}, 32'd0);
        run_access(vecs[0], 10);

        // Reset pulsed while in ACK
        cpu_start(24'h3FFFFE, 1'b0, 1'b0, 1'b1);
        ticks(4);
        sd_valid = 1'b0;
        tick();
        check("rst_ack.dtack", {31'd0, dtack}, 32'd0);
        sd_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        cpu_release();
        tick();
        check_reset_vals("rst_ack");
        rst_n = 1'b1;
        ticks(3);
        check_released("rst_ack.after");
        run_access(vecs[1], 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fastram_bus_frontend.md
Name: fastram_bus_frontend

Overview:
- 68000-side front end for the SDRAM fast-RAM controller.
- Synchronises the raw CPU strobes and decodes the fast-RAM address window.
- Presents qualified AS/UDS/LDS/RW/A to the SDRAM controller and turns its active-low VALID into DTACK, read-latch and data-buffer controls.
- Raises BERR on a stalled access. Sits directly upstream of the SDRAM controller, between CPU bus and controller.

Parameters:
- WIN_MATCH, 3'b001: value A[23:21] must equal (after masking) for a window hit.
- WIN_MASK, 3'b111: bits of A[23:21] that take part in the compare.
- TIMEOUT, 12'd2047: CLK cycles in ACCESS without VALID before BERR.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- CPU_AS  in  1  68000 address strobe, active low, asynchronous.
- CPU_UDS  in  1  upper data strobe, active low, asynchronous.
- CPU_LDS  in  1  lower data strobe, active low, asynchronous.
- CPU_RW  in  1  1 = read, asynchronous.
- CPU_A  in  23  CPU address A[23:1].
- SD_READY  in  1  controller initialising when 1.
- SD_VALID  in  1  controller data valid/complete, active low.
- SD_AS  out  1  qualified AS to controller, active low.
- SD_UDS  out  1  qualified UDS to controller, active low.
- SD_LDS  out  1  qualified LDS to controller, active low.
- SD_RW  out  1  latched RW to controller.
- SD_A  out  23  latched address to controller.
- DTACK  out  1  to CPU, active low.
- BERR  out  1  to CPU, active low.
- DLATCH  out  1  one-cycle high strobe capturing SDRAM read data into the CPU-side latch.
- BUF_OE  out  1  data buffer enable, active low.
- BUF_DIR  out  1  1 = SDRAM toward CPU.

Behaviour:
- Synchronisation:
  - CPU_AS/UDS/LDS/RW each pass through two flops (as_s, uds_s, lds_s, rw_s).
  - CPU_A is not synchronised. It is captured into SD_A on the cycle the FSM leaves IDLE, when as_s is low; the 68k guarantees A is stable by then.
- Hit: (CPU_A[23:21] & WIN_MASK) == (WIN_MATCH & WIN_MASK).
- Reset (RST low at CLK edge):
  - state = IDLE, counter = 0.
  - SD_AS = SD_UDS = SD_LDS = 1, SD_RW = 1, SD_A = 0.
  - DTACK = BERR = 1, DLATCH = 0, BUF_OE = 1, BUF_DIR = 0.
  - Sync flops preset to 1.
  - Reset mid-access drops everything inactive on the same edge.
- FSM states and transitions:
  - IDLE: all outputs inactive.
    - as_s=0 & hit & SD_READY=0 -> ACCESS: SD_AS <= 0, SD_RW <= rw_s, SD_A <= CPU_A, BUF_DIR <= rw_s, counter <= 0.
    - as_s=0 & hit & SD_READY=1 -> INITWAIT.
    - as_s=0 & miss -> IGNORE.
  - INITWAIT: no DTACK, no counting.
    - SD_READY falls -> ACCESS (same loads as above).
    - as_s rises -> IDLE.
  - IGNORE: outputs inactive. as_s=1 -> IDLE.
  - ACCESS:
    - SD_UDS <= uds_s, SD_LDS <= lds_s every cycle.
    - BUF_OE <= 0 from first ACCESS cycle.
    - counter increments, saturating at TIMEOUT.
    - Priority order: (1) as_s=1 (abort) -> IDLE, all outputs inactive, no DTACK; (2) SD_VALID=0 -> read: DLATCH <= 1, go LATCH; write: DTACK <= 0, go ACK; (3) counter == TIMEOUT -> BERR <= 0, go ERR.
  - LATCH: DLATCH <= 0, DTACK <= 0 -> ACK.
  - ACK: hold DTACK=0 and BUF_OE=0 until as_s=1. Then DTACK <= 1, BERR <= 1, SD_AS/UDS/LDS <= 1, BUF_OE <= 1 -> IDLE.
  - ERR: hold BERR=0 until as_s=1, then same release as ACK -> IDLE.
- Latency:
  - CPU_AS fall -> SD_AS fall: 3 CLK edges (2 sync + 1 register) when hit and ready.
  - SD_VALID low sampled at edge n: read gives DLATCH high after n, DTACK low after n+1; write gives DTACK low after n.
  - CPU_AS rise -> DTACK/SD_AS release: 3 edges.
- Simultaneous events: as_s rising in the same cycle as SD_VALID=0 counts as abort (no DTACK, no DLATCH). Timeout equality and SD_VALID=0 in the same cycle: VALID wins.
- DLATCH is high for exactly one cycle per completed read and never on a write.
- BUF_DIR is stable for the whole access.

Test Plan:
- Reset, then read at A=0x200000 with SD_READY=0; SD_VALID low 6 cycles after SD_AS falls -> SD_AS low 3 edges after CPU_AS; DLATCH single pulse; DTACK low the cycle after; BUF_DIR=1; release 3 edges after CPU_AS rises.
- Write at A=0x3FFFFE with UDS=0, LDS=1 -> SD_UDS=0, SD_LDS=1, SD_RW=0; DTACK low the edge after SD_VALID sampled low; DLATCH never pulses; BUF_DIR=0.
- Access at A=0x100000 (miss) -> SD_AS stays 1, DTACK and BERR stay 1, FSM returns to IDLE after CPU_AS rises.
- Hit while SD_READY=1 for 500 cycles, then SD_READY falls -> no BERR during wait; SD_AS falls the cycle after SD_READY sampled low; normal completion.
- Hit with SD_VALID held high -> BERR low at counter 2047; DTACK never asserted; BERR released after CPU_AS rises.
- CPU_AS rises during ACCESS before VALID, and separately RST pulsed low mid-ACK -> all outputs inactive, no DTACK, next access completes normally.
